alu_arbiter: RTL
================

# alu_arbiter

Shares one combinational ALU between NUM_REQ independent requesters. Each requester hands over an operation with a valid/ready handshake. A round-robin arbiter grants one request at a time, registers its operands onto the ALU ports, captures the ALU Result and returns it to the winning requester with a second valid/ready handshake. The block sits between client blocks and the ALU instance, and owns the ALU's Operand1/Operand2/OpCode inputs.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- WIDTH, 8: operand width.
- OP_W, 3: opcode width.
- RES_W, 8: ALU Result width.

Ports:
- Clock  in  1  single clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Req_Valid  in  NUM_REQ  per-requester request valid.
- Req_Ready  out  NUM_REQ  per-requester request accept; at most one bit high.
- Req_Operand1  in  NUM_REQ*WIDTH  packed; slice i belongs to requester i.
- Req_Operand2  in  NUM_REQ*WIDTH  packed.
- Req_OpCode  in  NUM_REQ*OP_W  packed.
- Rsp_Valid  out  NUM_REQ  per-requester response valid; at most one bit high.
- Rsp_Ready  in  NUM_REQ  per-requester response accept.
- Rsp_Result  out  RES_W  result; shared by all requesters, qualified by Rsp_Valid.
- Operand1  out  WIDTH  to ALU, registered.
- Operand2  out  WIDTH  to ALU, registered.
- OpCode  out  OP_W  to ALU, registered.
- Result  in  RES_W  from ALU.
- Busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any Req_Valid is high, pick winner g as the first requester with Req_Valid high, searching from Ptr upward with modulo-NUM_REQ wrap.
  - Req_Ready[g] = 1 combinationally, all other bits 0.
  - On the handshake, latch slice g into Operand1/Operand2/OpCode, store g in Grant, set Ptr = (g+1) mod NUM_REQ, go to EXEC.
- EXEC: ALU ports are stable. At the end of the cycle, capture Result into Rsp_Result and go to RESP.
- RESP:
  - Rsp_Valid[Grant] = 1.
  - Rsp_Ready[Grant] high: go to IDLE. Rsp_Valid drops the next cycle.
  - Rsp_Ready of non-granted requesters is ignored.
- Req_Ready is 0 in EXEC and RESP. New requests wait, and arbitration is re-evaluated on return to IDLE.
- Requester rule: Req_Valid and its operands stay stable until Req_Ready. The block does not check this.
- Operand1/Operand2/OpCode hold their last values outside EXEC; they are not cleared.
- Rsp_Result holds until the next capture.

## Timing
- Reset values: state IDLE, Ptr 0, Grant 0, Operand1/Operand2/OpCode 0, Rsp_Result 0, Rsp_Valid 0, Busy 0. Req_Ready follows Req_Valid combinationally from reset release.
- Latency:
  - Request handshake in cycle T.
  - EXEC in T+1.
  - Rsp_Valid high from T+2.
  - Back-to-back throughput with Rsp_Ready tied high is one operation per 3 cycles.
- Simultaneous requests: strict round-robin. Every requester with Valid held gets served within NUM_REQ grants.
- Ptr wrap: after granting NUM_REQ-1, Ptr becomes 0.
- Reset mid-operation (EXEC or RESP): the transaction is dropped, no response is issued, and all registers take their reset values.
- Result is assumed combinational and settled within one cycle of the operands.

## Structure
- Package alu_pkg holds:
  - the opcode constants: ALU_OP_ADD = 0, ALU_OP_SUB = 1, ALU_OP_AND = 2, ALU_OP_OR = 3, ALU_OP_XOR = 4;
  - the state enum state_t {IDLE, EXEC, RESP}.
- Sub-module rr_arbiter (NUM_REQ):
  - inputs: request vector, Ptr;
  - outputs: one-hot grant and encoded index.
  - Purely combinational, reusable elsewhere.

## Test plan
- Single request: Req_Valid[0] with 5 and 3, ALU_OP_ADD, Rsp_Ready[0]=1.
  - Req_Ready[0] high in cycle 0.
  - ALU ports 5/3/0 in cycle 1.
  - Rsp_Valid[0] with Rsp_Result=8 in cycle 2.
  - Busy low in cycle 3.
- Contention: all four Req_Valid high at once with distinct operands, Ptr=0.
  - Grants are 0,1,2,3 in order.
  - Each response arrives on the matching Rsp_Valid bit with the correct result.
- Wrap and fairness: requester 3 served, then 0 and 3 both request.
  - Requester 0 wins (Ptr wrapped to 0), then 3.
- Response backpressure: Rsp_Ready[1] low for 5 cycles.
  - Rsp_Valid[1] and Rsp_Result stay stable.
  - No Req_Ready is asserted during that time.
  - Response completes on the cycle Rsp_Ready[1] rises.
- Reset in EXEC: assert Reset during the cycle after a grant.
  - All outputs return to reset values immediately.
  - No Rsp_Valid ever appears.
  - A subsequent request on requester 2 is granted first (Ptr=0 scan, only 2 valid).
- Subtract with wrap-around: 2 - 5 with ALU_OP_SUB.
  - Rsp_Result = 8'hFD.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcode constants, FSM states and
// a round-robin pointer helper.
package alu_pkg;

  localparam logic [2:0] ALU_OP_ADD = 3'd0;
  localparam logic [2:0] ALU_OP_SUB = 3'd1;
  localparam logic [2:0] ALU_OP_AND = 3'd2;
  localparam logic [2:0] ALU_OP_OR  = 3'd3;
  localparam logic [2:0] ALU_OP_XOR = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  // Pointer position just past idx, wrapping at n.
  function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request bit found
// scanning upward from ptr with wrap-around.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters: round-robin grant,
// registered ALU operands, captured result returned over a response handshake.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned OP_W    = 3,
  parameter int unsigned RES_W   = 8
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [NUM_REQ-1:0]       Req_Valid,
  output logic [NUM_REQ-1:0]       Req_Ready,
  input  logic [NUM_REQ*WIDTH-1:0] Req_Operand1,
  input  logic [NUM_REQ*WIDTH-1:0] Req_Operand2,
  input  logic [NUM_REQ*OP_W-1:0]  Req_OpCode,
  output logic [NUM_REQ-1:0]       Rsp_Valid,
  input  logic [NUM_REQ-1:0]       Rsp_Ready,
  output logic [RES_W-1:0]         Rsp_Result,
  output logic [WIDTH-1:0]         Operand1,
  output logic [WIDTH-1:0]         Operand2,
  output logic [OP_W-1:0]          OpCode,
  input  logic [RES_W-1:0]         Result,
  output logic                     Busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [WIDTH-1:0]   op1_q, op1_d;
  logic [WIDTH-1:0]   op2_q, op2_d;
  logic [OP_W-1:0]    opc_q, opc_d;
  logic [RES_W-1:0]   res_q, res_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req (Req_Valid),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    opc_d     = opc_q;
    res_d     = res_q;
    Req_Ready = '0;
    Rsp_Valid = '0;
    unique case (state_q)
      IDLE: begin
        // Ready follows the arbiter grant, so any valid request handshakes now.
        if (|Req_Valid) begin
          Req_Ready = arb_gnt;
          op1_d     = Req_Operand1[arb_idx*WIDTH +: WIDTH];
          op2_d     = Req_Operand2[arb_idx*WIDTH +: WIDTH];
          opc_d     = Req_OpCode[arb_idx*OP_W +: OP_W];
          grant_d   = arb_idx;
          ptr_d     = IDX_W'(next_ptr(32'(arb_idx), NUM_REQ));
          state_d   = EXEC;
        end
      end
      EXEC: begin
        res_d   = Result;
        state_d = RESP;
      end
      RESP: begin
        Rsp_Valid = NUM_REQ'(1) << grant_q;
        if (Rsp_Ready[grant_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      opc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      opc_q   <= opc_d;
      res_q   <= res_d;
    end
  end

  assign Operand1   = op1_q;
  assign Operand2   = op2_q;
  assign OpCode     = opc_q;
  assign Rsp_Result = res_q;
  assign Busy       = (state_q != IDLE);

endmodule
